// File: rtl/hilo_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_muldiv
//  Description : HI/LO register pair with a single-cycle multiplier and a
//                32-iteration radix-2 restoring divider for the MIPS core.
//                Raises a stall while a division is in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv #(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [5:0]  funct_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o,
    output logic        stall_o
);

    localparam logic [5:0] c_FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] c_FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] c_FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] c_FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] c_FUNCT_MULT  = 6'h18;
    localparam logic [5:0] c_FUNCT_MULTU = 6'h19;
    localparam logic [5:0] c_FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] c_FUNCT_DIVU  = 6'h1B;

    localparam int c_CNT_W = $clog2(DIV_ITERS + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIV_RUN = 2'd1,
        S_DIV_FIX = 2'd2
    } state_t;

    state_t               r_state;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;
    logic                 r_busy;
    logic [31:0]          r_divisor;   // divisor magnitude
    logic [31:0]          r_quo;       // dividend bits shift out, quotient bits shift in
    logic [31:0]          r_rem;       // partial remainder
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_dbz;
    logic [31:0]          r_rs_orig;

    logic                 w_legal;
    logic                 w_accept;
    logic                 w_is_div;
    logic [31:0]          w_rs_mag;
    logic [31:0]          w_rt_mag;
    logic                 w_mul_signed;
    logic [63:0]          w_mul_a;
    logic [63:0]          w_mul_b;
    logic [63:0]          w_product;
    logic [32:0]          w_shift;
    logic                 w_ge;
    logic [31:0]          w_diff;
    logic [31:0]          w_rem_next;
    logic [31:0]          w_quo_fix;
    logic [31:0]          w_rem_fix;

    // Decode whether the presented funct belongs to this unit
    always_comb begin
        w_legal = 1'b0;
        case (funct_i)
            c_FUNCT_MFHI, c_FUNCT_MTHI, c_FUNCT_MFLO, c_FUNCT_MTLO,
            c_FUNCT_MULT, c_FUNCT_MULTU, c_FUNCT_DIV, c_FUNCT_DIVU:
                w_legal = 1'b1;
            default:
                w_legal = 1'b0;
        endcase
    end

    assign w_accept = valid_i & ~r_busy & w_legal;
    assign w_is_div = (funct_i == c_FUNCT_DIV);

    // Signed division works on magnitudes; 0x80000000 maps onto itself,
    // which is the correct unsigned magnitude.
    assign w_rs_mag = (w_is_div && rs_i[31]) ? (~rs_i + 32'd1) : rs_i;
    assign w_rt_mag = (w_is_div && rt_i[31]) ? (~rt_i + 32'd1) : rt_i;

    // Sign-extending to 64 bits makes the low 64 bits of the product the
    // signed result for MULT and the unsigned result for MULTU.
    assign w_mul_signed = (funct_i == c_FUNCT_MULT);
    assign w_mul_a      = {{32{w_mul_signed & rs_i[31]}}, rs_i};
    assign w_mul_b      = {{32{w_mul_signed & rt_i[31]}}, rt_i};
    assign w_product    = w_mul_a * w_mul_b;

    // One restoring step: shift in the next dividend bit and trial-subtract.
    // When the trial succeeds the difference is below the divisor, so a
    // 32-bit subtraction is exact.
    assign w_shift    = {r_rem, r_quo[31]};
    assign w_ge       = (w_shift >= {1'b0, r_divisor});
    assign w_diff     = w_shift[31:0] - r_divisor;
    assign w_rem_next = w_ge ? w_diff : w_shift[31:0];

    assign w_quo_fix = r_neg_q ? (~r_quo + 32'd1) : r_quo;
    assign w_rem_fix = r_neg_r ? (~r_rem + 32'd1) : r_rem;

    // Issue handling, HI/LO updates and the division sequencer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_busy    <= 1'b0;
            r_divisor <= 32'd0;
            r_quo     <= 32'd0;
            r_rem     <= 32'd0;
            r_cnt     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dbz     <= 1'b0;
            r_rs_orig <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (funct_i)
                            c_FUNCT_MTHI: r_hi <= rs_i;
                            c_FUNCT_MTLO: r_lo <= rs_i;
                            c_FUNCT_MULT, c_FUNCT_MULTU: begin
                                r_hi <= w_product[63:32];
                                r_lo <= w_product[31:0];
                            end
                            c_FUNCT_DIV, c_FUNCT_DIVU: begin
                                r_divisor <= w_rt_mag;
                                r_quo     <= w_rs_mag;
                                r_rem     <= 32'd0;
                                r_neg_q   <= w_is_div & (rs_i[31] ^ rt_i[31]);
                                r_neg_r   <= w_is_div & rs_i[31];
                                r_dbz     <= (rt_i == 32'd0);
                                r_rs_orig <= rs_i;
                                r_cnt     <= c_CNT_W'(DIV_ITERS);
                                r_busy    <= 1'b1;
                                r_state   <= S_DIV_RUN;
                            end
                            default: ;
                        endcase
                    end
                end
                S_DIV_RUN: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[30:0], w_ge};
                    r_cnt <= r_cnt - c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_state <= S_DIV_FIX;
                    end
                end
                S_DIV_FIX: begin
                    r_hi    <= r_dbz ? r_rs_orig : w_rem_fix;
                    r_lo    <= r_dbz ? 32'hFFFF_FFFF : w_quo_fix;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign hi_o    = r_hi;
    assign lo_o    = r_lo;
    assign busy_o  = r_busy;
    assign stall_o = valid_i & r_busy;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_muldiv
//  Description : Scoreboard bench for hilo_muldiv. Stimulus pushes expected
//                per-cycle observations and division results; a monitor pops
//                and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic [5:0]  funct_i;
    logic [31:0] rs_i;
    logic [31:0] rt_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy_o;
    logic        stall_o;

    hilo_muldiv #(.DIV_ITERS(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .funct_i (funct_i),
        .rs_i    (rs_i),
        .rt_i    (rt_i),
        .hi_o    (hi_o),
        .lo_o    (lo_o),
        .busy_o  (busy_o),
        .stall_o (stall_o)
    );

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef struct {
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        busy;
        logic        stall;
        int          id;
    } exp_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          id;
    } div_t;

    exp_t exp_q[$];
    div_t div_q[$];

    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Monitor: per-cycle observations and division completion on busy fall
    initial begin
        exp_t e;
        div_t d;
        int   run;
        run = 0;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                n_vec = n_vec + 1;
                if (e.cyc != cyc || hi_o !== e.hi || lo_o !== e.lo ||
                    busy_o !== e.busy || stall_o !== e.stall) begin
                    n_bad = n_bad + 1;
                    $display("FAIL step%0d cyc%0d: got hi=%h lo=%h busy=%b stall=%b, want hi=%h lo=%h busy=%b stall=%b (at cyc%0d)",
                             e.id, cyc, hi_o, lo_o, busy_o, stall_o,
                             e.hi, e.lo, e.busy, e.stall, e.cyc);
                end
            end
            if (busy_o === 1'b1) begin
                run = run + 1;
            end else begin
                if (run > 0 && div_q.size() > 0) begin
                    d = div_q.pop_front();
                    n_vec = n_vec + 1;
                    if (hi_o !== d.hi || lo_o !== d.lo || run != 33) begin
                        n_bad = n_bad + 1;
                        $display("FAIL div_done step%0d: got hi=%h lo=%h busy_cycles=%0d, want hi=%h lo=%h busy_cycles=33",
                                 d.id, hi_o, lo_o, run, d.hi, d.lo);
                    end
                end
                run = 0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_at(input int c, input logic [31:0] hi, input logic [31:0] lo,
                             input logic busy, input logic stall, input int id);
        exp_t e;
        e.cyc = c; e.hi = hi; e.lo = lo; e.busy = busy; e.stall = stall; e.id = id;
        exp_q.push_back(e);
    endtask

    // Single-cycle op: result expected the following cycle
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int id);
        tick();
        valid_i = 1'b1; funct_i = f; rs_i = a; rt_i = b;
        expect_at(cyc + 1, ehi, elo, 1'b0, 1'b0, id);
        m_hi = ehi; m_lo = elo;
    endtask

    // Division: 33 busy cycles with HI/LO unchanged, then the result;
    // optionally holds another instruction (stalled) throughout.
    task automatic div_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input logic hold, input logic [5:0] hf, input logic [31:0] hrs,
                          input int id);
        int   t;
        div_t d;
        tick();
        valid_i = 1'b1; funct_i = f; rs_i = a; rt_i = b;
        t = cyc;
        for (int k = 1; k <= 33; k++) begin
            expect_at(t + k, m_hi, m_lo, 1'b1, (k == 1) ? 1'b1 : hold, id);
        end
        expect_at(t + 34, ehi, elo, 1'b0, 1'b0, id);
        d.hi = ehi; d.lo = elo; d.id = id;
        div_q.push_back(d);
        for (int k = 1; k <= 34; k++) begin
            tick();
            valid_i = hold; funct_i = hf; rs_i = hrs; rt_i = 32'd0;
        end
        m_hi = ehi; m_lo = elo;
    endtask

    initial begin
        int t;
        rst_n = 1'b0; valid_i = 1'b0; funct_i = 6'd0; rs_i = 32'd0; rt_i = 32'd0;
        tick(); tick();
        expect_at(cyc + 1, 32'd0, 32'd0, 1'b0, 1'b0, 1);
        tick();
        rst_n = 1'b1;

        issue(F_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2);
        issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 3);
        issue(F_MTHI,  32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF, 32'h0000_0001, 4);
        issue(F_MTLO,  32'hCAFE_F00D, 32'h0,         32'hDEAD_BEEF, 32'hCAFE_F00D, 5);
        issue(6'h20,   32'h1111_1111, 32'h2222_2222, 32'hDEAD_BEEF, 32'hCAFE_F00D, 6);
        issue(F_MFLO,  32'h3333_3333, 32'h0,         32'hDEAD_BEEF, 32'hCAFE_F00D, 7);

        div_op(F_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, F_MFHI, 32'h0, 8);
        div_op(F_DIVU, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b0, F_MFHI, 32'h0, 9);
        // MTHI held during the division must take effect only after busy falls
        div_op(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b1, F_MTHI, 32'hA5A5_A5A5, 10);
        expect_at(cyc + 1, 32'hA5A5_A5A5, 32'h8000_0000, 1'b0, 1'b0, 10);
        m_hi = 32'hA5A5_A5A5;
        div_op(F_DIVU, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF, 1'b0, F_MFHI, 32'h0, 11);
        div_op(F_DIV,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, F_MFHI, 32'h0, 12);

        // Reset on busy cycle 10 of DIV 1000/7 abandons the division
        tick();
        valid_i = 1'b1; funct_i = F_DIV; rs_i = 32'd1000; rt_i = 32'd7;
        t = cyc;
        for (int k = 1; k <= 10; k++) begin
            expect_at(t + k, m_hi, m_lo, 1'b1, (k == 1) ? 1'b1 : 1'b0, 13);
        end
        expect_at(t + 11, 32'd0, 32'd0, 1'b0, 1'b0, 13);
        expect_at(t + 12, 32'd0, 32'd0, 1'b0, 1'b0, 13);
        for (int k = 1; k <= 9; k++) begin
            tick();
            valid_i = 1'b0;
        end
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        issue(F_MTHI, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'h0000_0000, 14);
        issue(F_MTLO, 32'h0000_5678, 32'h0, 32'h0000_1234, 32'h0000_5678, 15);

        tick();
        valid_i = 1'b0;
        repeat (3) tick();

        if (exp_q.size() != 0 || div_q.size() != 0) begin
            n_vec = n_vec + 1;
            n_bad = n_bad + 1;
            $display("FAIL pending_checks: got %0d cycle checks and %0d division results outstanding, want 0 and 0",
                     exp_q.size(), div_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
